// File: rtl/fwpic_irq_cond_if.sv
// Sideband bundle between the interrupt sources/config registers and the conditioner.
// The master drives the raw lines and their configuration; the slave returns clean requests.
interface fwpic_irq_cond_if #(
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq_i;
    logic [N_IRQ-1:0] polarity;
    logic [N_IRQ-1:0] edge_mode;
    logic [N_IRQ-1:0] enable;
    logic [N_IRQ-1:0] irq_o;

    modport master (
        output irq_i,
        output polarity,
        output edge_mode,
        output enable,
        input  irq_o
    );

    modport slave (
        input  irq_i,
        input  polarity,
        input  edge_mode,
        input  enable,
        output irq_o
    );
endinterface

// File: rtl/fwpic_irq_cond.sv
// Interrupt-source conditioner feeding fwpic: per-line synchroniser, polarity fix,
// debounce filter and level or stretched-pulse output, all fully registered.
module fwpic_irq_cond #(
    parameter int N_IRQ    = 8,
    parameter int DEBOUNCE = 4,
    parameter int STRETCH  = 3
) (
    input  logic             clock,
    input  logic             reset,
    fwpic_irq_cond_if.slave  bus
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam int STR_W = $clog2(STRETCH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);

    logic [N_IRQ-1:0] irq_vec;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
            logic             s1_reg;
            logic             s2_reg;
            logic             f_reg;
            logic             f_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [STR_W-1:0] str_reg;
            logic [STR_W-1:0] str_next;
            logic             irq_reg;
            logic             irq_next;
            logic             raw;
            logic             rise;

            // Debounce: raw must disagree with f for DEBOUNCE consecutive cycles.
            always_comb begin
                raw      = s2_reg ^ bus.polarity[gi];
                f_next   = f_reg;
                cnt_next = cnt_reg;
                rise     = 1'b0;
                if (raw == f_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    f_next   = raw;
                    cnt_next = '0;
                    rise     = raw;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            // A rising acceptance during a stretch reloads it, giving one longer pulse.
            always_comb begin
                str_next = str_reg;
                if (!bus.enable[gi]) begin
                    str_next = '0;
                end else if (rise && bus.edge_mode[gi]) begin
                    str_next = STR_LOAD;
                end else if (str_reg != '0) begin
                    str_next = str_reg - STR_W'(1);
                end
            end

            always_comb begin
                irq_next = 1'b0;
                if (bus.enable[gi]) begin
                    irq_next = bus.edge_mode[gi] ? (str_reg != '0) : f_reg;
                end
            end

            // Sync flops reset to the inactive level so no false edge follows release.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s1_reg  <= bus.polarity[gi];
                    s2_reg  <= bus.polarity[gi];
                    f_reg   <= 1'b0;
                    cnt_reg <= '0;
                    str_reg <= '0;
                    irq_reg <= 1'b0;
                end else begin
                    s1_reg  <= bus.irq_i[gi];
                    s2_reg  <= s1_reg;
                    f_reg   <= f_next;
                    cnt_reg <= cnt_next;
                    str_reg <= str_next;
                    irq_reg <= irq_next;
                end
            end

            assign irq_vec[gi] = irq_reg;
        end
    endgenerate

    assign bus.irq_o = irq_vec;
endmodule

// File: tb/tb_fwpic_irq_cond.sv
// Directed bench for fwpic_irq_cond: inputs change on the falling edge, and irq_o is
// sampled on the falling edge after the k-th rising edge that followed the change.
module tb_fwpic_irq_cond;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   fail_cnt  = 0;
    int   total_cnt = 0;

    fwpic_irq_cond_if #(.N_IRQ(8)) bus ();
    fwpic_irq_cond_if #(.N_IRQ(8)) bus_long ();

    fwpic_irq_cond #(.N_IRQ(8), .DEBOUNCE(4), .STRETCH(3)) u_dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Long stretch so a retrigger can land inside a running pulse.
    fwpic_irq_cond #(.N_IRQ(8), .DEBOUNCE(4), .STRETCH(16)) u_dut_long (
        .clock (clk),
        .reset (reset),
        .bus   (bus_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Expect irq_o[line] high exactly for k in [lo,hi]; release irq_i[line] after edge drop_at.
    task automatic window(input string tag, input int line, input int steps,
                          input int lo, input int hi, input int drop_at);
        for (int k = 1; k <= steps; k++) begin
            @(negedge clk);
            check($sformatf("%s_k%0d", tag, k), {7'd0, bus.irq_o[line]},
                  {7'd0, 1'(k >= lo && k <= hi)});
            if (k == drop_at) bus.irq_i[line] = 1'b0;
        end
        $display("step %s line %0d done", tag, line);
    endtask

    initial begin
        reset              = 1'b1;
        bus.irq_i          = 8'h08;
        bus.polarity       = 8'h08;
        bus.edge_mode      = 8'h00;
        bus.enable         = 8'hFF;
        bus_long.irq_i     = 8'h00;
        bus_long.polarity  = 8'h00;
        bus_long.edge_mode = 8'h01;
        bus_long.enable    = 8'hFF;
        repeat (3) @(negedge clk);
        check("reset_state", bus.irq_o, 8'h00);
        check("reset_state_long", bus_long.irq_o, 8'h00);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Level line: rises on edge 7, falls 7 edges after release.
        bus.irq_i[0] = 1'b1;
        window("level", 0, 20, 7, 16, 10);

        // Glitches: 3 cycles dropped, 4 cycles accepted.
        bus.irq_i[1] = 1'b1;
        window("glitch3", 1, 12, 100, 0, 3);
        bus.irq_i[1] = 1'b1;
        window("glitch4", 1, 14, 7, 10, 4);

        // Edge line: held 20 cycles gives exactly 3 cycles of irq_o from edge 7.
        bus.edge_mode[2] = 1'b1;
        bus.irq_i[2]     = 1'b1;
        window("edge", 2, 24, 7, 9, 20);
        repeat (8) @(negedge clk);

        // Retrigger: fall accepted at 14, new rise accepted at 20 reloads the 16-cycle stretch.
        bus_long.irq_i[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check($sformatf("retrig_k%0d", k), {7'd0, bus_long.irq_o[0]},
                  {7'd0, 1'(k >= 7 && k <= 36)});
            if (k == 8)  bus_long.irq_i[0] = 1'b0;
            if (k == 14) bus_long.irq_i[0] = 1'b1;
        end
        bus_long.irq_i[0] = 1'b0;
        $display("step retrigger done");

        // Active-low line idle high through reset stays quiet, then asserts on low.
        check("pol_idle", {7'd0, bus.irq_o[3]}, 8'h00);
        bus.irq_i[3] = 1'b0;
        window("pol_on", 3, 10, 7, 100, 0);
        bus.irq_i[3] = 1'b1;
        window("pol_off", 3, 10, 1, 6, 0);

        // Enable dropped mid-stretch clears the pulse; re-enable alone does not restart it.
        bus.edge_mode[4] = 1'b1;
        bus.irq_i[4]     = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("en_edge_k%0d", k), {7'd0, bus.irq_o[4]}, {7'd0, 1'(k == 7)});
            if (k == 7) bus.enable[4] = 1'b0;
            if (k == 9) bus.enable[4] = 1'b1;
        end
        $display("step enable_edge done");

        // Held level line re-enabled asserts next edge without re-debounce.
        bus.enable[4]    = 1'b0;
        bus.edge_mode[4] = 1'b0;
        @(negedge clk);
        check("en_lvl_off", {7'd0, bus.irq_o[4]}, 8'h00);
        bus.enable[4] = 1'b1;
        @(negedge clk);
        check("en_lvl_on", {7'd0, bus.irq_o[4]}, 8'h01);
        bus.irq_i[4] = 1'b0;
        window("en_lvl_rel", 4, 8, 1, 6, 0);

        // Reset while line 6 asserted and line 5 mid-debounce.
        bus.irq_i[6] = 1'b1;
        repeat (7) @(negedge clk);
        check("pre_reset", bus.irq_o, 8'h40);
        bus.edge_mode[5] = 1'b1;
        bus.irq_i[5]     = 1'b1;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        bus.irq_i = 8'h08;
        @(negedge clk);
        check("mid_reset", bus.irq_o, 8'h00);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_k%0d", k), bus.irq_o, 8'h00);
        end
        $display("step reset done");

        // All lines rise together, mixed modes: edge lines drop after 3 cycles.
        bus.polarity = 8'h00;
        bus.irq_i    = 8'h00;
        repeat (10) @(negedge clk);
        check("all_idle", bus.irq_o, 8'h00);
        bus.edge_mode = 8'hAA;
        bus.irq_i     = 8'hFF;
        for (int k = 1; k <= 12; k++) begin
            logic [7:0] exp;
            @(negedge clk);
            exp = (k < 7) ? 8'h00 : ((k <= 9) ? 8'hFF : 8'h55);
            check($sformatf("all_k%0d", k), bus.irq_o, exp);
        end
        $display("step all_lines done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
